// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor program memory.
// Holds the geometry, the NOP encoding and the loader FSM state encoding.
package simple_proc_pkg;

  localparam int DEPTH  = 1024;
  localparam int PC_W   = 10;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/prog_mem_array_1024x16.sv
// Instruction storage: synchronous write port, registered read port.
// Deliberately has no reset so the image survives rst.
module prog_mem_array_1024x16
  import simple_proc_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PC_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PC_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on load beats, register the read word when a fetch hits.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/simple_proc_prog_mem.sv
// Program-memory responder: loads a program from a host stream, pulses
// start into the processor and serves registered instruction fetches.
// Optional feature macro: SIMPLE_PROC_PROG_MEM_CHECKSUM_EN adds a
// 16-bit additive checksum over the loaded words (ld_csum / csum_err).
module simple_proc_prog_mem
  import simple_proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
  input  logic [DATA_W-1:0] ld_csum,
  output logic              csum_err,
`endif
  input  logic [PC_W-1:0]   pc,
  input  logic              ram_read_en,
  output logic [DATA_W-1:0] instr_out,
  output logic              start,
  output logic              busy,
  output logic [PC_W:0]     prog_len,
  output logic              len_err,
  output state_t            state_dbg
);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   wr_ptr;
  logic              beat, ptr_full, last_beat, start_load, csum_ok;
  logic              fetch_hit, sel_q;
  logic [DATA_W-1:0] rdata;

  // Load stream handshake: a word transfers on a rising edge where
  // ld_valid && ld_ready; ld_ready is a pure decode of the LOAD state and
  // never depends on ld_valid, so the host may hold valid across stalls.
  assign beat       = ld_valid && (state == ST_LOAD);
  assign ptr_full   = (wr_ptr == PC_W'(DEPTH - 1));
  assign last_beat  = beat && (ld_last || ptr_full);
  assign start_load = load_req && (state == ST_IDLE || state == ST_RUN);

`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  assign csum_ok = ((csum + ld_data) == ld_csum);
`else
  assign csum_ok = 1'b1;
`endif

  assign ld_ready  = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD);
  assign start     = (state == ST_START);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; load_req is only honoured in IDLE and RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load_req) state_nxt = ST_LOAD;
      ST_LOAD:  if (last_beat) state_nxt = csum_ok ? ST_START : ST_IDLE;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (load_req) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Write pointer, program length and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      prog_len <= '0;
      len_err  <= 1'b0;
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
      csum     <= '0;
      csum_err <= 1'b0;
`endif
    end else if (start_load) begin
      wr_ptr   <= '0;
      prog_len <= '0;
      len_err  <= 1'b0;
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
      csum     <= '0;
      csum_err <= 1'b0;
`endif
    end else if (beat) begin
      // The pointer wraps after word 1023, but LOAD is left on that beat so
      // no further write can land on word 0.
      wr_ptr   <= wr_ptr + PC_W'(1);
      prog_len <= prog_len + (PC_W + 1)'(1);
      if (ptr_full && !ld_last) len_err <= 1'b1;
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
      csum <= csum + ld_data;
      if (last_beat && !csum_ok) begin
        prog_len <= '0;
        csum_err <= 1'b1;
      end
`endif
    end
  end

  // A fetch only reaches the array in RUN and inside the loaded program.
  assign fetch_hit = (state == ST_RUN) && ({1'b0, pc} < prog_len);

  // Remember whether the last sampled fetch hit; a miss forces NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              sel_q <= 1'b0;
    else if (ram_read_en) sel_q <= fetch_hit;
  end

  assign instr_out = sel_q ? rdata : NOP_INSTR;

  prog_mem_array_1024x16 u_array (
    .clk   (clk),
    .we    (beat),
    .waddr (wr_ptr),
    .wdata (ld_data),
    .re    (ram_read_en && fetch_hit),
    .raddr (pc),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_simple_proc_prog_mem.sv
// Self-checking bench for simple_proc_prog_mem. The reference model is the
// loaded program as a queue: a fetch returns exp_q[pc] in RUN when pc is
// inside the program, NOP otherwise.
module tb_simple_proc_prog_mem;
  import simple_proc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req, ld_valid, ld_last, ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic [PC_W-1:0]   pc;
  logic              ram_read_en;
  logic [DATA_W-1:0] instr_out;
  logic              start, busy, len_err;
  logic [PC_W:0]     prog_len;
  state_t            state_dbg;
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] ld_csum;
  logic              csum_err;
`endif

  simple_proc_prog_mem dut (
    .clk         (clk),
    .rst         (rst),
    .load_req    (load_req),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
    .ld_csum     (ld_csum),
    .csum_err    (csum_err),
`endif
    .pc          (pc),
    .ram_read_en (ram_read_en),
    .instr_out   (instr_out),
    .start       (start),
    .busy        (busy),
    .prog_len    (prog_len),
    .len_err     (len_err),
    .state_dbg   (state_dbg)
  );

  // Clock and start-pulse monitor.
  always #5 clk = ~clk;

  int start_cnt = 0;
  always @(negedge clk) if (start === 1'b1) start_cnt++;

  // Scoreboard state.
  logic [DATA_W-1:0] exp_q[$];
  bit                running;
  bit                exp_len_err;
  int                exp_starts;
  logic [DATA_W-1:0] csum_acc;
  int                total = 0;
  int                bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load_req = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    pc = '0; ram_read_en = 0;
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
    ld_csum = '0;
`endif
    #1;
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_prog_len", prog_len, 0);
    tick();
    check("rst_instr", instr_out, 0);
    check("rst_start", start, 0);
    check("rst_len_err", len_err, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    tick();
    exp_q.delete();
    running = 0;
    exp_len_err = 0;
  endtask

  function automatic logic [DATA_W-1:0] ref_fetch(input int a);
    if (running && a < exp_q.size()) return exp_q[a];
    return NOP_INSTR;
  endfunction

  task automatic fetch(input int a);
    logic [DATA_W-1:0] e;
    e = ref_fetch(a);
    pc = PC_W'(a);
    ram_read_en = 1;
    tick();
    check("fetch", instr_out, e);
    ram_read_en = 0;
    pc = PC_W'($urandom);
    tick();
    check("fetch_hold", instr_out, e);
  endtask

  task automatic begin_load();
    load_req = 1;
    tick();
    load_req = 0;
    check("load_busy", busy, 1);
    check("load_ready", ld_ready, 1);
    check("load_len0", prog_len, 0);
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
    check("load_csum_err0", csum_err, 0);
`endif
    exp_q.delete();
    running = 0;
    exp_len_err = 0;
    csum_acc = '0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] w, input bit last, input int gaps,
                           input bit bad_csum);
    repeat (gaps) begin
      ld_valid = 0;
      ld_data  = DATA_W'($urandom);
      ld_last  = 1'($urandom_range(0, 1));
      load_req = 1'($urandom_range(0, 1));
      tick();
    end
    load_req = 0;
    csum_acc = csum_acc + w;
    ld_valid = 1;
    ld_data  = w;
    ld_last  = last;
`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
    ld_csum  = bad_csum ? (csum_acc ^ 16'h0001) : csum_acc;
`endif
    tick();
    ld_valid = 0;
    ld_last  = 0;
    exp_q.push_back(w);
    if (exp_q.size() == DEPTH && !last && !bad_csum) exp_len_err = 1;
  endtask

  task automatic end_load();
    #1;
    check("start_pulse", start, 1);
    check("start_ready", ld_ready, 0);
    check("start_busy", busy, 0);
    ld_valid = 1;
    ld_data  = DATA_W'($urandom);
    load_req = 1;
    tick();
    ld_valid = 0;
    load_req = 0;
    exp_starts++;
    running = 1;
    check("run_start_low", start, 0);
    check("run_state", state_dbg, ST_RUN);
    check("prog_len", prog_len, exp_q.size());
    check("len_err", len_err, exp_len_err);
  endtask

  task automatic load_random(input int n, input int max_gap);
    begin_load();
    for (int i = 0; i < n; i++)
      send_beat(DATA_W'($urandom), i == n - 1, $urandom_range(0, max_gap), 0);
    end_load();
  endtask

  initial begin
    int n;
    exp_starts = 0;
    do_reset();

    // After reset nothing is loaded.
    fetch(0);
    #1;
    check("no_start_after_rst", start_cnt, 0);
    check("idle_ready", ld_ready, 0);

    // Fixed three-word program.
    begin_load();
    send_beat(16'h1111, 0, 0, 0);
    send_beat(16'h2222, 0, 0, 0);
    send_beat(16'h3333, 1, 0, 0);
    end_load();
    fetch(1);
    fetch(5);
    fetch(0);
    fetch(2);
    fetch(3);

    // Random programs with valid gaps and ignored load_req pulses.
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(4, 20);
      load_random(n, 3);
      for (int j = 0; j < 8; j++) fetch($urandom_range(0, n + 4));
      fetch(n - 1);
      fetch(n);
    end

    // Full image without ld_last: forced end, len_err set.
    begin_load();
    for (int i = 0; i < DEPTH; i++)
      send_beat(DATA_W'($urandom), 0, ($urandom_range(0, 15) == 0) ? 1 : 0, 0);
    end_load();
    fetch(DEPTH - 1);
    fetch(0);
    for (int j = 0; j < 6; j++) fetch($urandom_range(0, DEPTH - 1));

    // Reset in the middle of a load discards the partial program.
    begin_load();
    send_beat(16'hAAAA, 0, 0, 0);
    send_beat(16'hBBBB, 0, 0, 0);
    do_reset();
    fetch(0);
    fetch(1);

    // load_req from RUN aborts the program; fetches return NOP while loading.
    load_random(6, 2);
    fetch(2);
    begin_load();
    fetch(0);
    fetch(3);
    send_beat(16'h0BAD, 0, 1, 0);
    send_beat(16'h0C0D, 1, 1, 0);
    end_load();
    fetch(0);
    fetch(1);
    fetch(2);

`ifdef SIMPLE_PROC_PROG_MEM_CHECKSUM_EN
    // Matching checksum: 0xFFFF + 0x0002 wraps to 0x0001.
    begin_load();
    send_beat(16'hFFFF, 0, 0, 0);
    send_beat(16'h0002, 1, 0, 0);
    end_load();
    check("csum_ok_err", csum_err, 0);
    fetch(0);
    // Mismatching checksum: back to IDLE, no start, length dropped.
    begin_load();
    send_beat(16'hFFFF, 0, 0, 0);
    send_beat(16'h0002, 1, 0, 1);
    #1;
    check("csum_bad_start", start, 0);
    check("csum_bad_err", csum_err, 1);
    check("csum_bad_state", state_dbg, ST_IDLE);
    check("csum_bad_len", prog_len, 0);
    exp_q.delete();
    running = 0;
    tick();
    fetch(0);
`endif

    repeat (3) tick();
    #1;
    check("start_count", start_cnt, exp_starts);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simple_proc_prog_mem.md
# simple_proc_prog_mem

Program-memory responder for the simple processor: holds the instruction image, answers the processor's `pc`/`ram_read_en` fetch requests with registered 16-bit instruction words, and accepts a new program from a host over a valid/ready load stream. When a load completes it pulses `start` into the processor. It sits between the host/loader and the processor's fetch port, driving the processor's `data_in`.

## Interface
- `DEPTH`, 1024, instruction words stored
- `PC_W`, 10, fetch address width (log2 DEPTH)
- `DATA_W`, 16, instruction width
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `load_req`  in  1  single-cycle request to begin a program load
- `ld_valid`  in  1  host word valid
- `ld_data`  in  DATA_W  host instruction word
- `ld_last`  in  1  qualifies final word of the program
- `ld_ready`  out  1  block accepts a word this cycle
- `pc`  in  PC_W  processor fetch address
- `ram_read_en`  in  1  processor fetch strobe
- `instr_out`  out  DATA_W  fetched instruction (to processor `data_in`)
- `start`  out  1  one-cycle pulse to processor after successful load
- `busy`  out  1  high while in LOAD
- `prog_len`  out  PC_W+1  words in current program (0..1024)
- `len_err`  out  1  sticky: 1024th word accepted without `ld_last`

## Operation
- FSM states: IDLE, LOAD, START, RUN.
- IDLE: `load_req` -> LOAD, write pointer = 0, `prog_len` = 0, `len_err` cleared.
- LOAD: `ld_ready` = 1, `busy` = 1. Beat = `ld_valid && ld_ready`; each beat writes `ld_data` at pointer, pointer++, `prog_len`++. Beat with `ld_last` -> START. Beat at pointer 1023 without `ld_last`: treated as last, `len_err` set, -> START (no wrap, no overwrite of word 0).
- `load_req` during LOAD or START: ignored.
- START: `start` = 1 for exactly one cycle, `ld_ready` = 0 -> RUN.
- RUN: fetches served. `load_req` -> LOAD (abort current program; processor must be held by host).
- Fetch: when `ram_read_en` sampled high in RUN, `instr_out` <= mem[`pc`] if `pc` < `prog_len`, else 16'h0000 (NOP). `ram_read_en` high in IDLE/LOAD/START -> `instr_out` <= 0. `ram_read_en` low -> `instr_out` holds.
- Memory array is not reset; contents survive `rst`. Since `prog_len` resets to 0, all fetches after reset return 0 until a load completes.

## Timing
- Reset values: `instr_out` 0, `start` 0, `ld_ready` 0, `busy` 0, `prog_len` 0, `len_err` 0, state IDLE.
- Fetch latency 1 cycle: `ram_read_en`/`pc` at edge N -> `instr_out` valid after edge N+1 and held.
- `ld_ready` is a registered state decode: rises the cycle after the `load_req` edge, falls the cycle after the last beat.
- `start` pulses the cycle after the last beat; RUN entered one cycle later.
- Zero-word load impossible: LOAD exits only on a beat.
- `rst` mid-load: immediate return to IDLE, partial program discarded (`prog_len` 0).

## Configuration
- `SIMPLE_PROC_PROG_MEM_CHECKSUM_EN` defined: adds input `ld_csum` (DATA_W, sampled on the last beat) and output `csum_err` (sticky, reset 0, cleared on `load_req`). Running sum mod 2^16 of all beats incl. last; match -> START; mismatch -> IDLE, `csum_err` = 1, no `start`, `prog_len` forced 0.
- Undefined: ports absent, last beat always -> START.

## Structure
- Shared package `simple_proc_pkg`: FSM state encoding, `DATA_W`, `PC_W`, `DEPTH`, `NOP_INSTR` = 16'h0000.
- Sub-module `prog_mem_array_1024x16`: synchronous write, registered read, no reset; top holds FSM, pointer, length, checksum.

## Test plan
- Reset, fetch pc=0 with read_en -> `instr_out` 0, `start` never pulses, `ld_ready` 0.
- Load 3 words 16'h1111/16'h2222/16'h3333 (last on third) -> one `start` pulse, `prog_len` 3; fetch pc=1 -> 16'h2222 next cycle; pc=5 -> 0.
- Load with ld_valid gaps and toggling during START -> only valid beats stored, order preserved, no extra writes.
- Stream 1024 words, no `ld_last` -> `len_err` 1, `prog_len` 1024, `start` pulses, pc=1023 returns last word, pc=0 returns first.
- `rst` after 2 of 4 words, then fetch pc=0 -> 0; `load_req` in RUN -> `busy` 1, fetches return 0.
- With checksum enabled: words 16'hFFFF, 16'h0002, `ld_csum` 16'h0001 -> `start`; `ld_csum` 16'h0000 -> `csum_err` 1, no `start`, IDLE.
